// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//   Steps the AES-128 datapath through the initial AddRoundKey (round 0,
//   one cycle) and NR cipher rounds of CPR cycles each. Started by a one-cycle
//   init from the run controller. Returns a one-cycle done pulse.
//
//   Ports
//     clk          rising-edge clock
//     rst_         synchronous reset, active HIGH
//     init         start request, honoured only in IDLE
//     stall        freezes sequencing in RUN (sampled at the edge; the cycle
//                  that follows repeats the current position with no strobe)
//     busy         high in RUN
//     round        current round 0..NR
//     sub_cnt      cycle index within the round, 0..CPR-1
//     first_round  RUN and round == 0
//     last_round   RUN and round == NR (datapath skips MixColumns)
//     rnd_strobe   final, unstalled cycle of a round: datapath loads state
//     rcon         round constant for the current round
//     done         one-cycle completion pulse
//
//   All outputs are registered. The always_comb block computes the value
//   every output register takes at the next edge.
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int NR  = 10,
    parameter int CPR = 4,
    parameter int SW  = (CPR > 1) ? $clog2(CPR) : 1
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          init,
    input  logic          stall,
    output logic          busy,
    output logic [3:0]    round,
    output logic [SW-1:0] sub_cnt,
    output logic          first_round,
    output logic          last_round,
    output logic          rnd_strobe,
    output logic [7:0]    rcon,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0]    LAST_RND = 4'(NR);
    localparam logic [SW-1:0] LAST_SUB = SW'(CPR - 1);

    state_t        state, state_n;
    logic [3:0]    round_n;
    logic [SW-1:0] sub_n;
    logic [7:0]    rcon_n;
    logic          busy_n, first_n, last_n, strobe_n, done_n;
    logic          rnd_end;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Round 0 is always a single cycle; later rounds end at sub_cnt == CPR-1.
    assign rnd_end = (round == 4'd0) || (sub_cnt == LAST_SUB);

    always_ff @(posedge clk) begin
        if (rst_) begin
            state       <= IDLE;
            round       <= 4'd0;
            sub_cnt     <= '0;
            rcon        <= 8'h01;
            busy        <= 1'b0;
            first_round <= 1'b0;
            last_round  <= 1'b0;
            rnd_strobe  <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            round       <= round_n;
            sub_cnt     <= sub_n;
            rcon        <= rcon_n;
            busy        <= busy_n;
            first_round <= first_n;
            last_round  <= last_n;
            rnd_strobe  <= strobe_n;
            done        <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        round_n  = round;
        sub_n    = sub_cnt;
        rcon_n   = rcon;
        busy_n   = 1'b0;
        first_n  = 1'b0;
        last_n   = 1'b0;
        strobe_n = 1'b0;
        done_n   = 1'b0;

        unique case (state)
            IDLE: begin
                round_n = 4'd0;
                sub_n   = '0;
                rcon_n  = 8'h01;
                if (init) begin
                    // Round 0 is a one-cycle round, so its strobe is
                    // already due in the first RUN cycle.
                    state_n  = RUN;
                    busy_n   = 1'b1;
                    first_n  = 1'b1;
                    last_n   = (LAST_RND == 4'd0);
                    strobe_n = 1'b1;
                end
            end

            RUN: begin
                busy_n = 1'b1;
                if (stall) begin
                    first_n = first_round;
                    last_n  = last_round;
                end else if (rnd_end && round == LAST_RND) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    if (rnd_end) begin
                        round_n = round + 4'd1;
                        sub_n   = '0;
                        // Round 1 reuses 0x01; only later advances apply xtime.
                        if (round != 4'd0)
                            rcon_n = xtime(rcon);
                    end else begin
                        sub_n = sub_cnt + SW'(1);
                    end
                    first_n  = (round_n == 4'd0);
                    last_n   = (round_n == LAST_RND);
                    strobe_n = (sub_n == LAST_SUB);
                end
            end

            DONE: begin
                state_n = IDLE;
                round_n = 4'd0;
                sub_n   = '0;
                rcon_n  = 8'h01;
            end

            default: begin
                state_n = IDLE;
                round_n = 4'd0;
                sub_n   = '0;
                rcon_n  = 8'h01;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_round_sequencer
//   Two instances share the stimulus: defaults (NR=10, CPR=4) and the CPR=1
//   corner. A reference model tracks each run as a position index into the
//   flattened sequence of round cycles and derives the expected outputs by
//   arithmetic. Directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_aes_round_sequencer;

    logic clk = 1'b0;
    logic rst_ = 1'b1, init = 1'b0, stall = 1'b0;

    logic       a_busy, a_first, a_last, a_stb, a_done;
    logic [3:0] a_round;
    logic [1:0] a_sub;
    logic [7:0] a_rcon;

    logic       b_busy, b_first, b_last, b_stb, b_done;
    logic [3:0] b_round;
    logic [0:0] b_sub;
    logic [7:0] b_rcon;

    always #5 clk = ~clk;

    aes_round_sequencer #(.NR(10), .CPR(4)) dut_a (
        .clk(clk), .rst_(rst_), .init(init), .stall(stall),
        .busy(a_busy), .round(a_round), .sub_cnt(a_sub),
        .first_round(a_first), .last_round(a_last), .rnd_strobe(a_stb),
        .rcon(a_rcon), .done(a_done)
    );

    aes_round_sequencer #(.NR(10), .CPR(1)) dut_b (
        .clk(clk), .rst_(rst_), .init(init), .stall(stall),
        .busy(b_busy), .round(b_round), .sub_cnt(b_sub),
        .first_round(b_first), .last_round(b_last), .rnd_strobe(b_stb),
        .rcon(b_rcon), .done(b_done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int  nr  [2] = '{10, 10};
    int  cpr [2] = '{4, 1};
    bit  m_run [2];
    bit  m_done[2];
    bit  m_frz [2];
    int  m_pos [2];
    byte unsigned rtab [0:10] = '{8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    task automatic model_edge(input int k, input bit r, input bit i, input bit s);
        if (r) begin
            m_run[k] = 0; m_done[k] = 0; m_frz[k] = 0; m_pos[k] = 0;
        end else if (m_done[k]) begin
            m_done[k] = 0;
        end else if (!m_run[k]) begin
            if (i) begin m_run[k] = 1; m_pos[k] = 0; m_frz[k] = 0; end
        end else if (s) begin
            m_frz[k] = 1;
        end else if (m_pos[k] == nr[k] * cpr[k]) begin
            m_run[k] = 0; m_done[k] = 1; m_pos[k] = 0; m_frz[k] = 0;
        end else begin
            m_pos[k]++; m_frz[k] = 0;
        end
    endtask

    function automatic int exp_round(input int k);
        if (!m_run[k] || m_pos[k] == 0) return 0;
        return (m_pos[k] - 1) / cpr[k] + 1;
    endfunction

    function automatic int exp_sub(input int k);
        if (!m_run[k] || m_pos[k] == 0) return 0;
        return (m_pos[k] - 1) % cpr[k];
    endfunction

    task automatic check_inst(input int k, input string nm, input logic bsy,
                              input logic [3:0] rnd, input logic [3:0] sc,
                              input logic fr, input logic lr, input logic stb,
                              input logic [7:0] rc, input logic dn);
        int er, es;
        er = exp_round(k);
        es = exp_sub(k);
        chk({nm, ".busy"},  32'(bsy), 32'(m_run[k]));
        chk({nm, ".done"},  32'(dn),  32'(m_done[k]));
        if (!m_done[k]) begin
            chk({nm, ".round"}, 32'(rnd), 32'(er));
            chk({nm, ".sub"},   32'(sc),  32'(es));
            chk({nm, ".rcon"},  32'(rc),  32'(rtab[er]));
        end
        chk({nm, ".first"},  32'(fr),  32'(m_run[k] && er == 0));
        chk({nm, ".last"},   32'(lr),  32'(m_run[k] && er == nr[k]));
        chk({nm, ".strobe"}, 32'(stb),
            32'(m_run[k] && !m_frz[k] && (m_pos[k] == 0 || es == cpr[k] - 1)));
    endtask

    // ---------------- activity counters ----------------
    int cyc = 0;
    int c_busy[2], c_stb[2], c_done[2], t_done[2];

    task automatic clr_cnt();
        for (int k = 0; k < 2; k++) begin
            c_busy[k] = 0; c_stb[k] = 0; c_done[k] = 0; t_done[k] = -1;
        end
    endtask

    // One clock: drive on the falling edge, update the model at the rising
    // edge, compare 1 time unit later.
    task automatic step(input bit r, input bit i, input bit s);
        @(negedge clk);
        rst_ = r; init = i; stall = s;
        @(posedge clk);
        model_edge(0, r, i, s);
        model_edge(1, r, i, s);
        #1;
        cyc++;
        check_inst(0, "a", a_busy, a_round, {2'b0, a_sub}, a_first, a_last, a_stb, a_rcon, a_done);
        check_inst(1, "b", b_busy, b_round, {3'b0, b_sub}, b_first, b_last, b_stb, b_rcon, b_done);
        c_busy[0] += int'(a_busy); c_stb[0] += int'(a_stb); c_done[0] += int'(a_done);
        c_busy[1] += int'(b_busy); c_stb[1] += int'(b_stb); c_done[1] += int'(b_done);
        if (a_done && t_done[0] < 0) t_done[0] = cyc;
        if (b_done && t_done[1] < 0) t_done[1] = cyc;
    endtask

    int t_e;

    initial begin
        // Reset for two edges, then idle.
        step(1, 0, 0);
        step(1, 0, 0);
        clr_cnt();
        for (int n = 0; n < 10; n++) step(0, 0, 0);
        chk("idle.busy_cnt", 32'(c_busy[0] + c_busy[1]), 0);
        chk("idle.stb_cnt",  32'(c_stb[0] + c_stb[1]), 0);

        // Full unstalled run. t_e labels the E+1 cycle.
        clr_cnt();
        step(0, 1, 0);
        t_e = cyc;
        for (int n = 0; n < 46; n++) step(0, 0, 0);
        chk("run.a_busy_cnt", 32'(c_busy[0]), 41);
        chk("run.a_stb_cnt",  32'(c_stb[0]), 11);
        chk("run.a_done_cnt", 32'(c_done[0]), 1);
        chk("run.a_done_at",  32'(t_done[0] - t_e + 1), 42);
        chk("run.b_busy_cnt", 32'(c_busy[1]), 11);
        chk("run.b_stb_cnt",  32'(c_stb[1]), 11);
        chk("run.b_done_at",  32'(t_done[1] - t_e + 1), 12);

        // Stall three cycles at round 5, sub_cnt 2 (position 1+4*4+2).
        clr_cnt();
        step(0, 1, 0);
        t_e = cyc;
        for (int n = 0; n < 60 && !(m_run[0] && m_pos[0] == 19); n++) step(0, 0, 0);
        chk("stall.reached", 32'(m_pos[0]), 19);
        for (int n = 0; n < 3; n++) begin
            step(0, 0, 1);
            chk("stall.a_rcon", 32'(a_rcon), 32'h10);
        end
        for (int n = 0; n < 45; n++) step(0, 0, 0);
        chk("stall.a_done_at", 32'(t_done[0] - t_e + 1), 45);
        chk("stall.a_stb_cnt", 32'(c_stb[0]), 11);

        // Reset during round 7, then a full run.
        clr_cnt();
        step(0, 1, 0);
        for (int n = 0; n < 60 && exp_round(0) < 7; n++) step(0, 0, 0);
        step(1, 0, 0);
        for (int n = 0; n < 20; n++) step(0, 0, 0);
        chk("abort.a_done_cnt", 32'(c_done[0]), 0);
        clr_cnt();
        step(0, 1, 0);
        for (int n = 0; n < 46; n++) step(0, 0, 0);
        chk("rerun.a_busy_cnt", 32'(c_busy[0]), 41);
        chk("rerun.a_done_cnt", 32'(c_done[0]), 1);

        // Spurious init in round 3 and in DONE; init right after DONE restarts.
        clr_cnt();
        step(0, 1, 0);
        for (int n = 0; n < 60 && exp_round(0) < 3; n++) step(0, 0, 0);
        step(0, 1, 0);
        for (int n = 0; n < 60 && !m_done[0]; n++) step(0, 0, 0);
        step(0, 1, 0);
        chk("spur.a_done_cnt", 32'(c_done[0]), 1);
        chk("spur.a_busy_cnt", 32'(c_busy[0]), 41);
        step(0, 1, 0);
        chk("spur.restart", 32'(a_busy), 1);
        for (int n = 0; n < 45; n++) step(0, 0, 0);

        // Randomized traffic.
        for (int n = 0; n < 800; n++)
            step($urandom_range(0, 99) < 2, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
